// File: rtl/vred_pkg.sv
// Shared op encoding and bitwise reduction primitives for the logical-reduction datapath.
package vred_pkg;

    typedef enum logic [1:0] {
        OPSEL_NONE = 2'b00,
        OPSEL_AND  = 2'b01,
        OPSEL_OR   = 2'b10,
        OPSEL_XOR  = 2'b11
    } vred_op_e;

    // Identity bit for the op: a masked lane contributes this value on every bit
    function automatic logic red_identity(input vred_op_e op);
        return (op == OPSEL_AND);
    endfunction

    // Single-bit combine; OPSEL_NONE forces zero so the whole result collapses to 0
    function automatic logic red_combine(input vred_op_e op, input logic a, input logic b);
        logic r;
        case (op)
            OPSEL_AND: r = a & b;
            OPSEL_OR:  r = a | b;
            OPSEL_XOR: r = a ^ b;
            default:   r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/vred_logic_tree.sv
// Combinational pairwise reducer: masked lanes become the op identity, then
// log2(LANES) levels of pairwise combining produce a single element.
module vred_logic_tree
    import vred_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LANES      = 4
) (
    input  vred_op_e                      op,
    input  logic [LANES*DATA_WIDTH-1:0]   data,
    input  logic [LANES-1:0]              mask,
    output logic [DATA_WIDTH-1:0]         result
);

    localparam int unsigned LEVELS = $clog2(LANES);

    logic [DATA_WIDTH-1:0] ident;

    // Replicated identity value used for inactive lanes
    always_comb begin
        ident = {DATA_WIDTH{red_identity(op)}};
    end

    for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
        logic [DATA_WIDTH-1:0] node [LANES >> l];

        if (l == 0) begin : g_leaf
            // Leaves: active lanes pass through, masked lanes take the identity
            always_comb begin
                for (int unsigned j = 0; j < LANES; j++) begin
                    node[j] = mask[j] ? data[j*DATA_WIDTH +: DATA_WIDTH] : ident;
                end
            end
        end else begin : g_pair
            // Internal level: combine adjacent pairs from the level below
            always_comb begin
                for (int unsigned j = 0; j < (LANES >> l); j++) begin
                    for (int unsigned b = 0; b < DATA_WIDTH; b++) begin
                        node[j][b] = red_combine(op, g_lvl[l-1].node[2*j][b],
                                                     g_lvl[l-1].node[2*j+1][b]);
                    end
                end
            end
        end
    end

    assign result = g_lvl[LEVELS].node[0];

endmodule

// File: rtl/vred_logic_accum.sv
// Multi-beat logical reduction (and/or/xor) with scalar seed, a lane-tree stage (S1),
// a cross-beat accumulator and a held valid/ready result register.
module vred_logic_accum
    import vred_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned LANES       = 4,
    parameter int unsigned OPSEL_WIDTH = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [LANES*DATA_WIDTH-1:0]   in_data,
    input  logic [LANES-1:0]              in_mask,
    input  logic [DATA_WIDTH-1:0]         in_scalar,
    input  logic                          in_first,
    input  logic                          in_last,
    input  logic [OPSEL_WIDTH-1:0]        in_opSel,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic                          busy
);

    logic                  stall;
    logic                  accept;
    logic                  take;
    vred_op_e              beat_op;
    logic [DATA_WIDTH-1:0] tree_out;

    // Vector state: op latched on the first beat, open until the last beat is accepted
    vred_op_e              op_q;
    logic                  open_q;
    logic [DATA_WIDTH-1:0] seed_q;

    // S1 stage: tree result plus tags
    logic                  s1_valid;
    logic [DATA_WIDTH-1:0] s1_data;
    logic                  s1_first;
    logic                  s1_last;
    vred_op_e              s1_op;

    logic [DATA_WIDTH-1:0] acc_q;
    logic [DATA_WIDTH-1:0] acc_base;
    logic [DATA_WIDTH-1:0] acc_next;

    // Handshake and per-beat op selection; stray non-first beats are accepted but not taken
    always_comb begin
        stall    = out_valid & ~out_ready;
        in_ready = ~stall;
        accept   = in_valid & ~stall;
        take     = accept & (in_first | open_q);
        beat_op  = in_first ? vred_op_e'(in_opSel[1:0]) : op_q;
        busy     = open_q | s1_valid | out_valid;
    end

    vred_logic_tree #(
        .DATA_WIDTH (DATA_WIDTH),
        .LANES      (LANES)
    ) u_tree (
        .op     (beat_op),
        .data   (in_data),
        .mask   (in_mask),
        .result (tree_out)
    );

    // Accumulator update: first beat folds the seed, later beats fold the running value
    always_comb begin
        acc_base = s1_first ? seed_q : acc_q;
        for (int unsigned b = 0; b < DATA_WIDTH; b++) begin
            acc_next[b] = red_combine(s1_op, acc_base[b], s1_data[b]);
        end
    end

    // Pipeline registers; everything downstream of the input holds while the output stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q      <= OPSEL_NONE;
            open_q    <= 1'b0;
            seed_q    <= '0;
            s1_valid  <= 1'b0;
            s1_data   <= '0;
            s1_first  <= 1'b0;
            s1_last   <= 1'b0;
            s1_op     <= OPSEL_NONE;
            acc_q     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            if (take) begin
                open_q <= ~in_last;
            end
            if (take && in_first) begin
                op_q <= beat_op;
            end
            if (!stall) begin
                s1_valid <= take;
                if (take) begin
                    s1_data  <= tree_out;
                    s1_first <= in_first;
                    s1_last  <= in_last;
                    s1_op    <= beat_op;
                    // Safe to overwrite: any older first beat in S1 consumes seed_q this same edge
                    if (in_first) begin
                        seed_q <= in_scalar;
                    end
                end
                out_valid <= s1_valid & s1_last;
                if (s1_valid) begin
                    acc_q <= acc_next;
                    if (s1_last) begin
                        out_data <= acc_next;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_vred_logic_accum.sv
// Scoreboard bench for vred_logic_accum: directed vectors push expected results,
// a negedge monitor pops and compares on every output handshake.
module tb_vred_logic_accum;

    localparam int unsigned DW = 32;
    localparam int unsigned LN = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [LN*DW-1:0]  in_data;
    logic [LN-1:0]     in_mask;
    logic [DW-1:0]     in_scalar;
    logic              in_first;
    logic              in_last;
    logic [1:0]        in_opSel;
    logic              out_valid;
    logic              out_ready;
    logic [DW-1:0]     out_data;
    logic              busy;

    logic [31:0] exp_q [$];
    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    vred_logic_accum #(
        .DATA_WIDTH  (DW),
        .LANES       (LN),
        .OPSEL_WIDTH (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mask   (in_mask),
        .in_scalar (in_scalar),
        .in_first  (in_first),
        .in_last   (in_last),
        .in_opSel  (in_opSel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every accepted result is compared against the head of the scoreboard
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result: got 0x%08h expected none", out_data);
            end else begin
                chk("result", out_data, exp_q.pop_front());
            end
        end
    end

    task automatic send(input logic f, input logic l, input logic [1:0] op,
                        input logic [31:0] seed, input logic [31:0] d0, input logic [31:0] d1,
                        input logic [31:0] d2, input logic [31:0] d3, input logic [3:0] m);
        int n = 0;
        in_first  = f;
        in_last   = l;
        in_opSel  = op;
        in_scalar = seed;
        in_data   = {d3, d2, d1, d0};
        in_mask   = m;
        in_valid  = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: in_ready got 0 expected 1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out();
        int n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 20) begin
            checks++;
            failures++;
            $display("FAIL wait_out_timeout: out_valid got 0 expected 1");
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 50) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: pending got %0d expected 0", exp_q.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_mask   = '0;
        in_scalar = '0;
        in_first  = 1'b0;
        in_last   = 1'b0;
        in_opSel  = 2'b00;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  out_data,       32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single-beat XOR with latency check
        exp_q.push_back(32'h0000_000F);
        send(1, 1, 2'b11, 32'h0, 32'h1, 32'h2, 32'h4, 32'h8, 4'hF);
        chk("lat_t1_valid", 32'(out_valid), 32'd0);
        chk("lat_t1_busy",  32'(busy),      32'd1);
        @(posedge clk);
        #1;
        chk("lat_t2_valid", 32'(out_valid), 32'd1);

        // Two-beat AND, opSel on the second beat ignored
        exp_q.push_back(32'h0F0F_000F);
        send(1, 0, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_00FF, 32'hFFFF_00FF, 32'hFFFF_00FF, 32'hFFFF_00FF, 4'hF);
        send(0, 1, 2'b00, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0F0F_0F0F, 32'hFFFF_FFFF, 4'hF);

        // Mask to identity
        exp_q.push_back(32'h0000_0030);
        send(1, 1, 2'b10, 32'h0, 32'h10, 32'h20, 32'h30, 32'h40, 4'b0101);
        exp_q.push_back(32'h1234_5678);
        send(1, 1, 2'b01, 32'h1234_5678, 32'h0, 32'h0, 32'h0, 32'h0, 4'h0);
        exp_q.push_back(32'h0000_00A5);
        send(1, 1, 2'b10, 32'hA5, 32'hFF, 32'hFF, 32'hFF, 32'hFF, 4'h0);
        exp_q.push_back(32'h0000_005A);
        send(1, 1, 2'b11, 32'h5A, 32'h1234, 32'h1234, 32'h1234, 32'h1234, 4'h0);
        wait_drain();

        // Backpressure: result held, next vector waits and is still correct
        out_ready = 1'b0;
        exp_q.push_back(32'h0000_0011);
        send(1, 1, 2'b11, 32'h1, 32'h10, 32'h0, 32'h0, 32'h0, 4'hF);
        wait_out();
        exp_q.push_back(32'h0000_010F);
        fork
            send(1, 1, 2'b10, 32'h100, 32'h1, 32'h2, 32'h4, 32'h8, 4'hF);
            begin
                for (int i = 0; i < 5; i++) begin
                    chk("bp_in_ready",  32'(in_ready),  32'd0);
                    chk("bp_out_valid", 32'(out_valid), 32'd1);
                    chk("bp_out_data",  out_data,       32'h0000_0011);
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        wait_drain();

        // Restart discards the open vector; op changes mid-vector are ignored; op 00 -> 0
        exp_q.push_back(32'h0000_0003);
        send(1, 0, 2'b10, 32'hFF, 32'hF0, 32'hF0, 32'hF0, 32'hF0, 4'hF);
        send(1, 0, 2'b11, 32'h0, 32'h1, 32'h0, 32'h0, 32'h0, 4'hF);
        send(0, 1, 2'b01, 32'hFFFF_FFFF, 32'h2, 32'h0, 32'h0, 32'h0, 4'hF);
        exp_q.push_back(32'h0000_0000);
        send(1, 1, 2'b00, 32'hFFFF, 32'hFF, 32'hFF, 32'hFF, 32'hFF, 4'hF);
        wait_drain();

        // Stray non-first beat with no open vector is dropped
        send(0, 1, 2'b11, 32'h0, 32'h7, 32'h0, 32'h0, 32'h0, 4'hF);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("drop_busy",      32'(busy),      32'd0);
        chk("drop_out_valid", 32'(out_valid), 32'd0);

        // Reset while a partial vector is accumulating
        send(1, 0, 2'b11, 32'h0, 32'h5, 32'h0, 32'h0, 32'h0, 4'hF);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_busy",      32'(busy),      32'd0);
        chk("mid_rst_in_ready",  32'(in_ready),  32'd1);
        chk("mid_rst_out_data",  out_data,       32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        // Open-vector state must be gone: this last beat is dropped
        send(0, 1, 2'b11, 32'h0, 32'h9, 32'h0, 32'h0, 32'h0, 4'hF);
        exp_q.push_back(32'hFF0F_0F0F);
        send(1, 1, 2'b11, 32'h0F0F_0F0F, 32'hF000_0000, 32'h0, 32'h0, 32'h0, 4'hF);
        wait_drain();
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("final_pending", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
